// File: rtl/hs_dpath_pkg.sv
// Shared helpers for the hs_dpath family: occupancy width function and the
// common depth bound used by elastic datapath blocks.
package hs_dpath_pkg;

  localparam int HS_DPATH_MAX_DEPTH = 1024;

  function automatic int hs_cnt_w(int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hs_dpath_sfr_elastic_stage.sv
// One elastic stage: valid bit plus payload register, advancing on its enable.
// Data reset/flush is present only with HS_DPATH_SFR_ELASTIC_DATA_RST_EN defined.
module hs_dpath_sfr_elastic_stage #(
  parameter type      DATA_TYPE   = logic,
  parameter DATA_TYPE RESET_VALUE = DATA_TYPE'(1'b0)
) (
  input  logic     clk_i,
  input  logic     sresetn_i,
  input  logic     flush_i,
  input  logic     ce_i,
  input  logic     valid_i,
  input  DATA_TYPE data_i,
  output logic     valid_o,
  output DATA_TYPE data_o
);

  logic     valid_q, valid_d;
  DATA_TYPE data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (ce_i) begin
      valid_d = valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!sresetn_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

`ifdef HS_DPATH_SFR_ELASTIC_DATA_RST_EN
  always_comb begin
    data_d = data_q;
    if (flush_i) begin
      data_d = RESET_VALUE;
    end else if (ce_i && valid_i) begin
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!sresetn_i) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end
`else
  // Payload loads only under an incoming valid; no reset term keeps it cheap.
  always_comb begin
    data_d = data_q;
    if (ce_i && valid_i) begin
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  logic [$bits(DATA_TYPE)-1:0] reset_value_unused;
  assign reset_value_unused = RESET_VALUE;
`endif

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/hs_dpath_sfr_elastic.sv
// Elastic DEPTH-stage shift register with valid/ready flow control, taps and
// occupancy. Optional data reset via HS_DPATH_SFR_ELASTIC_DATA_RST_EN.
module hs_dpath_sfr_elastic
  import hs_dpath_pkg::*;
#(
  parameter type      DATA_TYPE   = logic,
  parameter DATA_TYPE RESET_VALUE = DATA_TYPE'(1'b0),
  parameter int       DEPTH       = 1,
  localparam int      CNT_W       = hs_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             sresetn,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  DATA_TYPE         s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output DATA_TYPE         m_data,
  output logic [DEPTH-1:0] tap_valid,
  output DATA_TYPE         tap_data [DEPTH],
  output logic [CNT_W-1:0] occupancy
);

  if (DEPTH < 1 || DEPTH > HS_DPATH_MAX_DEPTH) begin : g_depth_check
    $error("hs_dpath_sfr_elastic: DEPTH out of range 1..1024");
  end

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] vin;
  DATA_TYPE         din [DEPTH];
  logic             s_hs, m_hs;
  logic [CNT_W-1:0] occ_q, occ_d;

  // A stage may advance if it is empty or everything downstream can move;
  // this is a deliberate combinational path across all stages.
  always_comb begin
    rdy            = '0;
    rdy[DEPTH-1]   = m_ready | ~tap_valid[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      rdy[i] = rdy[i+1] | ~tap_valid[i];
    end
  end

  assign s_ready = rdy[0] & ~flush & sresetn;
  assign m_valid = tap_valid[DEPTH-1];
  assign m_data  = tap_data[DEPTH-1];
  assign s_hs    = s_valid & s_ready;
  assign m_hs    = m_valid & m_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign vin[i] = s_hs;
      assign din[i] = s_data;
    end else begin : g_body
      assign vin[i] = tap_valid[i-1];
      assign din[i] = tap_data[i-1];
    end

    hs_dpath_sfr_elastic_stage #(
      .DATA_TYPE  (DATA_TYPE),
      .RESET_VALUE(RESET_VALUE)
    ) u_stage (
      .clk_i    (clk),
      .sresetn_i(sresetn),
      .flush_i  (flush),
      .ce_i     (rdy[i]),
      .valid_i  (vin[i]),
      .data_i   (din[i]),
      .valid_o  (tap_valid[i]),
      .data_o   (tap_data[i])
    );
  end

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (s_hs && !m_hs) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (!s_hs && m_hs) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_hs_dpath_sfr_elastic.sv
// Bench for hs_dpath_sfr_elastic at DEPTH=4, 8-bit payload: directed scenarios
// plus random traffic against an in-order queue of accepted items.
module tb_hs_dpath_sfr_elastic;

  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] data;
    int         acc;
  } item_t;

  logic       clk = 1'b0;
  logic       sresetn, flush, s_valid, s_ready, m_valid, m_ready;
  logic [7:0] s_data, m_data;
  logic [DEPTH-1:0] tap_valid;
  logic [7:0] tap_data [DEPTH];
  logic [2:0] occupancy;

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  bit    chkLat = 1'b0;
  item_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hs_dpath_sfr_elastic #(
    .DATA_TYPE(logic [7:0]),
    .DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .sresetn  (sresetn),
    .flush    (flush),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .tap_valid(tap_valid),
    .tap_data (tap_data),
    .occupancy(occupancy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs; an accepted item becomes an expected output.
  task automatic applyStimulus(input logic sv, input logic [7:0] d, input logic mr,
                               input logic fl, output logic acc);
    @(posedge clk);
    #1;
    s_valid = sv;
    s_data  = d;
    m_ready = mr;
    flush   = fl;
    @(negedge clk);
    acc = s_valid && s_ready;
    if (!sresetn || flush) q.delete();
    if (acc) q.push_back('{d, cyc + 1});
  endtask

  always @(posedge clk) begin
    item_t it;
    #3;
    checkOutput("occupancy_vs_model", 32'(occupancy), 32'(q.size()));
    if (m_valid && m_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_output: got %0h, expected no item", m_data);
      end else begin
        it = q.pop_front();
        checkOutput("m_data_order", 32'(m_data), 32'(it.data));
        if (chkLat) checkOutput("latency", 32'(cyc - it.acc), 32'(DEPTH - 1));
      end
    end
  end

  initial begin
    logic       acc, sv, mr, fl;
    logic [7:0] d;
    int         nAcc;

    sresetn = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hAA;
    m_ready = 1'b0;

    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, acc);
    checkOutput("reset_accept", 32'(acc), 32'd0);
    checkOutput("reset_s_ready", 32'(s_ready), 32'd0);
    checkOutput("reset_m_valid", 32'(m_valid), 32'd0);
    checkOutput("reset_occupancy", 32'(occupancy), 32'd0);
    checkOutput("reset_tap_valid", 32'(tap_valid), 32'd0);
`ifdef HS_DPATH_SFR_ELASTIC_DATA_RST_EN
    for (int i = 0; i < DEPTH; i++) checkOutput("reset_tap_data", 32'(tap_data[i]), 32'd0);
`endif

    @(posedge clk);
    #1;
    sresetn = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("release_s_ready", 32'(s_ready), 32'd1);

    // Streaming
    chkLat = 1'b1;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 8'(k + 1), 1'b1, 1'b0, acc);
      checkOutput("stream_accept", 32'(acc), 32'd1);
      if (k >= 4) checkOutput("stream_occupancy", 32'(occupancy), 32'd4);
    end
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);
    chkLat = 1'b0;

    // Backpressure
    nAcc = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 8'(nAcc + 1), 1'b0, 1'b0, acc);
      if (acc) nAcc++;
    end
    checkOutput("bp_accepted", 32'(nAcc), 32'd4);
    checkOutput("bp_s_ready", 32'(s_ready), 32'd0);
    checkOutput("bp_occupancy", 32'(occupancy), 32'd4);
    checkOutput("bp_tap_valid", 32'(tap_valid), 32'hF);
    for (int i = 0; i < DEPTH; i++) checkOutput("bp_tap_data", 32'(tap_data[i]), 32'(DEPTH - i));
    applyStimulus(1'b1, 8'h05, 1'b1, 1'b0, acc);
    checkOutput("bp_release_accept", 32'(acc), 32'd1);
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Bubble collapse
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, acc);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);
    checkOutput("bubble_tap_valid", 32'(tap_valid), 32'hC);
    checkOutput("bubble_occupancy", 32'(occupancy), 32'd2);
    checkOutput("bubble_stage3", 32'(tap_data[3]), 32'h11);
    checkOutput("bubble_stage2", 32'(tap_data[2]), 32'h22);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Flush with a completing output handshake
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 8'(8'h31 + k), 1'b0, 1'b0, acc);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);
    checkOutput("preflush_tap_valid", 32'(tap_valid), 32'hE);
    checkOutput("preflush_m_data", 32'(m_data), 32'h31);
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b1, acc);
    checkOutput("flush_s_ready", 32'(s_ready), 32'd0);
    checkOutput("flush_accept", 32'(acc), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);
    checkOutput("postflush_tap_valid", 32'(tap_valid), 32'd0);
    checkOutput("postflush_occupancy", 32'(occupancy), 32'd0);
    checkOutput("postflush_m_valid", 32'(m_valid), 32'd0);
`ifdef HS_DPATH_SFR_ELASTIC_DATA_RST_EN
    for (int i = 0; i < DEPTH; i++) checkOutput("postflush_tap_data", 32'(tap_data[i]), 32'd0);
`endif

    // Random traffic; a pending offer is held until accepted
    sv  = 1'b0;
    d   = 8'h00;
    acc = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if (!(sv && !acc)) begin
        sv = 1'($urandom_range(0, 1));
        d  = 8'($urandom);
      end
      mr = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 59) == 0);
      applyStimulus(sv, d, mr, fl, acc);
    end
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);
    checkOutput("drain_queue_empty", 32'(q.size()), 32'd0);
    checkOutput("drain_m_valid", 32'(m_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
